smc_wr_strobe_gen: RTL

SMC_WR_STROBE_GEN -- requirements
Module: smc_wr_strobe_gen

---
 rtl/smc_wr_pkg.sv | 14 +
 rtl/smc_wr_phase_cnt.sv | 27 ++
 rtl/smc_wr_strobe_gen.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/smc_wr_pkg.sv
// Shared definitions for the static-memory write strobe generator.
package smc_wr_pkg;

  localparam int SMC_WR_NUM_LANES = 4;
  localparam int SMC_WR_CNT_W     = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_PULSE = 2'd2,
    ST_HOLD  = 2'd3
  } smc_wr_state_e;

endpackage

// File: rtl/smc_wr_phase_cnt.sv
// Loadable down-counter timing one write phase; saturates at zero.
module smc_wr_phase_cnt #(
  parameter int CNT_W = 4
) (
  input  logic             hclk,
  input  logic             n_sys_reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge hclk or negedge n_sys_reset) begin
    if (!n_sys_reset) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/smc_wr_strobe_gen.sv
// Static-memory write cycle sequencer: SETUP / PULSE / HOLD with per-lane enables.
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_IDLE  | waiting for start; strobes high
// ST_SETUP | address/data setup before the strobe
// ST_PULSE | smc_n_wr low, selected smc_n_we lanes low
// ST_HOLD  | data hold after the strobe
module smc_wr_strobe_gen
  import smc_wr_pkg::*;
#(
  parameter int NUM_LANES = SMC_WR_NUM_LANES,
  parameter int CNT_W     = SMC_WR_CNT_W
) (
  input  logic                 hclk,
  input  logic                 n_sys_reset,
  input  logic                 start,
  input  logic                 abort,
  input  logic [NUM_LANES-1:0] wr_lanes,
  input  logic [CNT_W-1:0]     cfg_setup,
  input  logic [CNT_W-1:0]     cfg_pulse,
  input  logic [CNT_W-1:0]     cfg_hold,
  input  logic                 cfg_we_en,
  output logic [NUM_LANES-1:0] smc_n_we,
  output logic                 smc_n_wr,
  output logic                 busy,
  output logic                 done
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  smc_wr_state_e        state_q, state_d;
  logic [NUM_LANES-1:0] lanes_q, lanes_eff;
  logic                 we_en_q, we_en_eff;
  logic [CNT_W-1:0]     pulse_m1_q, hold_q;
  logic [CNT_W-1:0]     in_pulse_m1;
  logic                 accept;
  logic                 cnt_load, cnt_dec, cnt_zero;
  logic [CNT_W-1:0]     cnt_load_val;
  logic                 done_d;

  // Counter holds (phase length - 1); a zero pulse length behaves as one cycle.
  assign in_pulse_m1 = (cfg_pulse == '0) ? '0 : (cfg_pulse - CNT_ONE);

  smc_wr_phase_cnt #(.CNT_W(CNT_W)) u_phase_cnt (
    .hclk        (hclk),
    .n_sys_reset (n_sys_reset),
    .load        (cnt_load),
    .load_val    (cnt_load_val),
    .dec         (cnt_dec),
    .zero        (cnt_zero)
  );

  always_ff @(posedge hclk or negedge n_sys_reset) begin
    if (!n_sys_reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    accept       = 1'b0;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    cnt_dec      = 1'b0;
    done_d       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          accept   = 1'b1;
          cnt_load = 1'b1;
          if (cfg_setup != '0) begin
            state_d      = ST_SETUP;
            cnt_load_val = cfg_setup - CNT_ONE;
          end else begin
            state_d      = ST_PULSE;
            cnt_load_val = in_pulse_m1;
          end
        end
      end
      ST_SETUP: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (cnt_zero) begin
          state_d      = ST_PULSE;
          cnt_load     = 1'b1;
          cnt_load_val = pulse_m1_q;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_PULSE: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (cnt_zero) begin
          if (hold_q != '0) begin
            state_d      = ST_HOLD;
            cnt_load     = 1'b1;
            cnt_load_val = hold_q - CNT_ONE;
          end else begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_HOLD: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (cnt_zero) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge hclk or negedge n_sys_reset) begin
    if (!n_sys_reset) begin
      lanes_q    <= '0;
      we_en_q    <= 1'b0;
      pulse_m1_q <= '0;
      hold_q     <= '0;
    end else if (accept) begin
      lanes_q    <= wr_lanes;
      we_en_q    <= cfg_we_en;
      pulse_m1_q <= in_pulse_m1;
      hold_q     <= cfg_hold;
    end
  end

  // A zero-setup transfer enters PULSE on the accepting edge, before the latches update.
  assign lanes_eff = accept ? wr_lanes  : lanes_q;
  assign we_en_eff = accept ? cfg_we_en : we_en_q;

  always_ff @(posedge hclk or negedge n_sys_reset) begin
    if (!n_sys_reset) begin
      smc_n_we <= '1;
      smc_n_wr <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      smc_n_we <= ((state_d == ST_PULSE) && we_en_eff) ? ~lanes_eff : '1;
      smc_n_wr <= (state_d != ST_PULSE);
      busy     <= (state_d != ST_IDLE);
      done     <= done_d;
    end
  end

endmodule
